// File: rtl/dsram_arbiter.sv
// Data-SRAM arbiter between pipeline LSU (m0) and uncached/debug/DMA (m1).
// Round-robin with starvation cap, m1 lock and per-beat read-return tags.
module dsram_arbiter #(
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic [3:0]  m0_wen,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic [3:0]  m1_wen,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic        m1_lock,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        sram_en,
  output logic [3:0]  sram_wen,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata,
  output logic        stallreq
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int T  = RD_LAT - 1;

  typedef enum logic {IDLE, OWN1_LOCK} state_e;

  state_e            state_q, state_d;
  logic              rr_q, rr_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic [RD_LAT-1:0] tv_q, tv_d;
  logic [RD_LAT-1:0] to_q, to_d;
  logic              req0, req1, both, force0;
  logic              g0, g1, rd, pend0;

  // Requests are masked in reset so every output reads 0
  assign req0   = m0_req & rst;
  assign req1   = m1_req & rst;
  assign both   = req0 & req1;
  assign force0 = req0 & (starve_q == SW'(STARVE_MAX));

  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    unique case (state_q)
      OWN1_LOCK: begin
        if (force0)    g0 = 1'b1;
        else if (req1) g1 = 1'b1;
      end
      default: begin
        if (both) begin
          if (force0 || !rr_q) g0 = 1'b1;
          else                 g1 = 1'b1;
        end else begin
          g0 = req0;
          g1 = req1;
        end
      end
    endcase
  end

  // rr_q=1 means m1 is favoured on the next contended cycle
  always_comb begin
    state_d  = (g1 & m1_lock) ? OWN1_LOCK : IDLE;
    rr_d     = (both & (g0 | g1)) ? g0 : rr_q;
    starve_d = starve_q;
    if (g0 || !req0)
      starve_d = '0;
    else if (g1 && starve_q != SW'(STARVE_MAX))
      starve_d = starve_q + SW'(1);
  end

  assign rd = (g0 & ~|m0_wen) | (g1 & ~|m1_wen);

  always_comb begin
    tv_d    = '0;
    to_d    = '0;
    tv_d[0] = rd;
    to_d[0] = g1;
    for (int i = 1; i < RD_LAT; i++) begin
      tv_d[i] = tv_q[i-1];
      to_d[i] = to_q[i-1];
    end
    pend0 = 1'b0;
    for (int i = 0; i < T; i++)
      pend0 = pend0 | (tv_q[i] & ~to_q[i]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      rr_q     <= 1'b0;
      starve_q <= '0;
      tv_q     <= '0;
      to_q     <= '0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      starve_q <= starve_d;
      tv_q     <= tv_d;
      to_q     <= to_d;
    end
  end

  always_comb begin
    sram_en    = 1'b0;
    sram_wen   = '0;
    sram_addr  = '0;
    sram_wdata = '0;
    unique case (1'b1)
      g0: begin
        sram_en    = 1'b1;
        sram_wen   = m0_wen;
        sram_addr  = m0_addr;
        sram_wdata = m0_wdata;
      end
      g1: begin
        sram_en    = 1'b1;
        sram_wen   = m1_wen;
        sram_addr  = m1_addr;
        sram_wdata = m1_wdata;
      end
      default: ;
    endcase
  end

  assign m0_gnt    = g0;
  assign m1_gnt    = g1;
  assign m0_rvalid = tv_q[T] & ~to_q[T];
  assign m1_rvalid = tv_q[T] & to_q[T];
  assign m0_rdata  = m0_rvalid ? sram_rdata : '0;
  assign m1_rdata  = m1_rvalid ? sram_rdata : '0;
  assign stallreq  = (req0 & ~g0) | pend0;

endmodule

// File: tb/tb_dsram_arbiter.sv
// Bench for dsram_arbiter: RD_LAT=1 and RD_LAT=3 copies on shared stimulus,
// checked every cycle against a behavioural model plus directed literals.
module tb_dsram_arbiter;

  localparam int SMAX = 4;
  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic r0, r1, lk;
  logic [3:0] w0, w1;
  logic [31:0] a0, a1, d0, d1;

  logic [1:0] m0_gnt_w, m0_rv_w, m1_gnt_w, m1_rv_w, en_w, st_w;
  logic [1:0][31:0] m0_rd_w, m1_rd_w, addr_w, wd_w, srd_w;
  logic [1:0][3:0] wen_w;

  always #5 clk = ~clk;

  dsram_arbiter #(.RD_LAT(LAT0), .STARVE_MAX(SMAX)) u0 (
    .clk(clk), .rst(rst),
    .m0_req(r0), .m0_wen(w0), .m0_addr(a0), .m0_wdata(d0),
    .m0_gnt(m0_gnt_w[0]), .m0_rvalid(m0_rv_w[0]), .m0_rdata(m0_rd_w[0]),
    .m1_req(r1), .m1_wen(w1), .m1_addr(a1), .m1_wdata(d1), .m1_lock(lk),
    .m1_gnt(m1_gnt_w[0]), .m1_rvalid(m1_rv_w[0]), .m1_rdata(m1_rd_w[0]),
    .sram_en(en_w[0]), .sram_wen(wen_w[0]), .sram_addr(addr_w[0]),
    .sram_wdata(wd_w[0]), .sram_rdata(srd_w[0]), .stallreq(st_w[0])
  );

  dsram_arbiter #(.RD_LAT(LAT1), .STARVE_MAX(SMAX)) u1 (
    .clk(clk), .rst(rst),
    .m0_req(r0), .m0_wen(w0), .m0_addr(a0), .m0_wdata(d0),
    .m0_gnt(m0_gnt_w[1]), .m0_rvalid(m0_rv_w[1]), .m0_rdata(m0_rd_w[1]),
    .m1_req(r1), .m1_wen(w1), .m1_addr(a1), .m1_wdata(d1), .m1_lock(lk),
    .m1_gnt(m1_gnt_w[1]), .m1_rvalid(m1_rv_w[1]), .m1_rdata(m1_rd_w[1]),
    .sram_en(en_w[1]), .sram_wen(wen_w[1]), .sram_addr(addr_w[1]),
    .sram_wdata(wd_w[1]), .sram_rdata(srd_w[1]), .stallreq(st_w[1])
  );

  function automatic logic [31:0] dflt(input int i);
    return (i == 0) ? 32'hDEADBEEF : ((32'h01010101 * 32'(i)) ^ 32'hC0DE0000);
  endfunction

  // SRAM environment per instance, latency set by the instance
  logic [31:0] mem_s [2][16];
  logic [31:0] rp_d  [2][4];
  logic        rp_v  [2][4];
  logic [31:0] junk;

  always @(posedge clk) begin
    junk <= $urandom;
    for (int k = 0; k < 2; k++) begin
      for (int j = 3; j > 0; j--) begin
        rp_d[k][j] <= rp_d[k][j-1];
        rp_v[k][j] <= rp_v[k][j-1];
      end
      rp_v[k][0] <= en_w[k] && (wen_w[k] == 4'h0);
      rp_d[k][0] <= mem_s[k][addr_w[k][5:2]];
      if (!rst) begin
        for (int i = 0; i < 16; i++) mem_s[k][i] <= dflt(i);
        for (int j = 0; j < 4; j++) rp_v[k][j] <= 1'b0;
      end else if (en_w[k]) begin
        for (int b = 0; b < 4; b++)
          if (wen_w[k][b])
            mem_s[k][addr_w[k][5:2]][8*b +: 8] <= wd_w[k][8*b +: 8];
      end
    end
  end

  assign srd_w[0] = rp_v[0][0] ? rp_d[0][0] : junk;
  assign srd_w[1] = rp_v[1][2] ? rp_d[1][2] : junk;

  // Behavioural model state
  int checks = 0;
  int fails  = 0;
  int cyc_n  = 0;
  int rr, st, mg;
  bit lkd;
  logic [31:0] mmem [16];
  logic        ev [2][8];
  logic        eo [2][8];
  logic [31:0] ed [2][8];

  logic [1:0] s_g0, s_g1, s_rv0, s_rv1, s_st, s_en;
  logic [1:0][31:0] s_rd0, s_rd1, s_addr, s_wd;
  logic [1:0][3:0] s_wen;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc_n, act, exp);
    end
  endtask

  task automatic model_step();
    int lat, s;
    bit frc, pend, rv0, rv1;
    logic e_en;
    logic [3:0] e_wen;
    logic [31:0] e_addr, e_wd;
    s_g0 = m0_gnt_w; s_g1 = m1_gnt_w; s_rv0 = m0_rv_w; s_rv1 = m1_rv_w;
    s_st = st_w; s_en = en_w; s_rd0 = m0_rd_w; s_rd1 = m1_rd_w;
    s_addr = addr_w; s_wd = wd_w; s_wen = wen_w;
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("rst_m0_gnt%0d", k), 32'(m0_gnt_w[k]), 0);
        chk($sformatf("rst_m1_gnt%0d", k), 32'(m1_gnt_w[k]), 0);
        chk($sformatf("rst_rv%0d", k), 32'(m0_rv_w[k] | m1_rv_w[k]), 0);
        chk($sformatf("rst_rdata%0d", k), m0_rd_w[k] | m1_rd_w[k], 0);
        chk($sformatf("rst_sram%0d", k),
            32'(en_w[k]) | 32'(wen_w[k]) | addr_w[k] | wd_w[k], 0);
        chk($sformatf("rst_stall%0d", k), 32'(st_w[k]), 0);
      end
      rr = 0; st = 0; lkd = 0; mg = -1;
      for (int k = 0; k < 2; k++)
        for (int j = 0; j < 8; j++) ev[k][j] = 1'b0;
      for (int i = 0; i < 16; i++) mmem[i] = dflt(i);
      cyc_n++;
      return;
    end
    frc = r0 && (st == SMAX);
    mg = -1;
    if (lkd) begin
      if (frc) mg = 0;
      else if (r1) mg = 1;
    end else if (r0 && r1) mg = (frc || rr == 0) ? 0 : 1;
    else if (r0) mg = 0;
    else if (r1) mg = 1;
    e_en = (mg >= 0);
    e_wen = (mg == 0) ? w0 : (mg == 1) ? w1 : 4'h0;
    e_addr = (mg == 0) ? a0 : (mg == 1) ? a1 : 32'h0;
    e_wd = (mg == 0) ? d0 : (mg == 1) ? d1 : 32'h0;
    for (int k = 0; k < 2; k++) begin
      lat = (k == 0) ? LAT0 : LAT1;
      s = cyc_n % 8;
      chk($sformatf("m0_gnt%0d", k), 32'(m0_gnt_w[k]), 32'(mg == 0));
      chk($sformatf("m1_gnt%0d", k), 32'(m1_gnt_w[k]), 32'(mg == 1));
      chk($sformatf("sram_en%0d", k), 32'(en_w[k]), 32'(e_en));
      chk($sformatf("sram_wen%0d", k), 32'(wen_w[k]), 32'(e_wen));
      chk($sformatf("sram_addr%0d", k), addr_w[k], e_addr);
      chk($sformatf("sram_wdata%0d", k), wd_w[k], e_wd);
      rv0 = ev[k][s] && !eo[k][s];
      rv1 = ev[k][s] && eo[k][s];
      chk($sformatf("m0_rvalid%0d", k), 32'(m0_rv_w[k]), 32'(rv0));
      chk($sformatf("m1_rvalid%0d", k), 32'(m1_rv_w[k]), 32'(rv1));
      chk($sformatf("m0_rdata%0d", k), m0_rd_w[k], rv0 ? ed[k][s] : 32'h0);
      chk($sformatf("m1_rdata%0d", k), m1_rd_w[k], rv1 ? ed[k][s] : 32'h0);
      pend = 0;
      for (int j = 1; j < lat; j++)
        if (ev[k][(cyc_n+j)%8] && !eo[k][(cyc_n+j)%8]) pend = 1;
      chk($sformatf("stallreq%0d", k), 32'(st_w[k]),
          32'((r0 && mg != 0) || pend));
      ev[k][s] = 1'b0;
      if (e_en && e_wen == 4'h0) begin
        ev[k][(cyc_n+lat)%8] = 1'b1;
        eo[k][(cyc_n+lat)%8] = (mg == 1);
        ed[k][(cyc_n+lat)%8] = mmem[e_addr[5:2]];
      end
    end
    for (int b = 0; b < 4; b++)
      if (e_en && e_wen[b]) mmem[e_addr[5:2]][8*b +: 8] = e_wd[8*b +: 8];
    if (r0 && r1 && mg >= 0) rr = (mg == 0) ? 1 : 0;
    if (!r0 || mg == 0) st = 0;
    else if (mg == 1 && st < SMAX) st++;
    lkd = (mg == 1) && lk;
    cyc_n++;
  endtask

  task automatic cyc();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    r0 = 1'b1; w0 = 4'h0; a0 = 32'h100; d0 = 32'h0;
    r1 = 1'b1; w1 = 4'h0; a1 = 32'h40; d1 = 32'h0; lk = 1'b1;
    cyc();
    chk("t1_rst_gnt", 32'(s_g0[0]), 0);
    chk("t1_rst_en", 32'(s_en[0]), 0);
    cyc();
    rst = 1'b1; r1 = 1'b0; lk = 1'b0;
    cyc();
    chk("t1_gnt", 32'(s_g0[0]), 1);
    rst = 1'b0; r0 = 1'b0;
    cyc();
    chk("t1_rv_inrst", 32'(s_rv0[0]), 0);
    rst = 1'b1;
    cyc();
    chk("t1_rv_drop", 32'(s_rv0[0]), 0);
    cyc();
    chk("t1_rv_drop3", 32'(s_rv0[1]), 0);
    r0 = 1'b1; a0 = 32'h100; r1 = 1'b1; a1 = 32'h40;
    cyc();
    chk("t1_first_g0", 32'(s_g0[0]), 1);
    chk("t1_first_g1", 32'(s_g1[0]), 0);
    r0 = 1'b0;
    cyc();
    r1 = 1'b0;
    repeat (4) cyc();

    r0 = 1'b1; a0 = 32'h100; w0 = 4'h0;
    cyc();
    chk("t2_gnt", 32'(s_g0[0]), 1);
    chk("t2_stall", 32'(s_st[0]), 0);
    r0 = 1'b0;
    cyc();
    chk("t2_rv", 32'(s_rv0[0]), 1);
    chk("t2_rdata", s_rd0[0], 32'hDEADBEEF);
    chk("t2_stall_rv", 32'(s_st[0]), 0);
    repeat (3) cyc();

    rst = 1'b0;
    cyc();
    rst = 1'b1;
    r0 = 1'b1; r1 = 1'b1; a0 = 32'h8; a1 = 32'hC;
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("t3_g0", 32'(s_g0[0]), 32'(i % 2 == 0));
      chk("t3_g1", 32'(s_g1[0]), 32'(i % 2 == 1));
      chk("t3_stall", 32'(s_st[0]), 32'(i % 2 == 1));
      chk("t3_rv0", 32'(s_rv0[0]), 32'(i % 2 == 1));
      chk("t3_rv1", 32'(s_rv1[0]), 32'(i % 2 == 0 && i > 0));
      if (i % 2 == 0) a0 = $urandom & 32'hFFFF_FFFC;
      else a1 = $urandom & 32'hFFFF_FFFC;
    end
    r0 = 1'b0; r1 = 1'b0;
    repeat (3) cyc();

    r1 = 1'b1; lk = 1'b1; w1 = 4'h0; a1 = 32'h80;
    cyc();
    chk("t4_lock_start", 32'(s_g1[0]), 1);
    r0 = 1'b1; a0 = 32'h100; w0 = 4'h0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (i < 4) begin
        chk("t4_g1", 32'(s_g1[0]), 1);
        chk("t4_stall", 32'(s_st[0]), 1);
      end else begin
        chk("t4_g0_forced", 32'(s_g0[0]), 1);
        chk("t4_g1_off", 32'(s_g1[0]), 0);
      end
    end
    r0 = 1'b0;
    cyc();
    chk("t4_regrant", 32'(s_g1[0]), 1);
    lk = 1'b0;
    cyc();
    r1 = 1'b0;
    repeat (3) cyc();

    r1 = 1'b1; w1 = 4'b0011; a1 = 32'h204; d1 = 32'h1234;
    cyc();
    chk("t5_en", 32'(s_en[0]), 1);
    chk("t5_wen", 32'(s_wen[0]), 32'h3);
    chk("t5_addr", s_addr[0], 32'h204);
    chk("t5_wdata", s_wd[0], 32'h1234);
    r1 = 1'b0; w1 = 4'h0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("t5_norv", 32'(s_rv1[0] | s_rv1[1]), 0);
    end
    r0 = 1'b1; a0 = 32'h204; w0 = 4'h0;
    cyc();
    r0 = 1'b0;
    cyc();
    chk("t5_rb_rv", 32'(s_rv0[0]), 1);
    chk("t5_rb_data", s_rd0[0], 32'hC1DF1234);
    repeat (3) cyc();

    r0 = 1'b1; a0 = 32'h100;
    cyc();
    chk("t6_stall_a", 32'(s_st[1]), 0);
    a0 = 32'h208;
    cyc();
    chk("t6_stall_b", 32'(s_st[1]), 1);
    a0 = 32'h30C;
    cyc();
    chk("t6_stall_c", 32'(s_st[1]), 1);
    r0 = 1'b0;
    cyc();
    chk("t6_rv_a", 32'(s_rv0[1]), 1);
    chk("t6_rd_a", s_rd0[1], 32'hDEADBEEF);
    chk("t6_stall_ra", 32'(s_st[1]), 1);
    cyc();
    chk("t6_rv_b", 32'(s_rv0[1]), 1);
    chk("t6_rd_b", s_rd0[1], 32'hC2DC0202);
    chk("t6_stall_rb", 32'(s_st[1]), 1);
    cyc();
    chk("t6_rv_c", 32'(s_rv0[1]), 1);
    chk("t6_rd_c", s_rd0[1], 32'hC3DD0303);
    chk("t6_stall_rc", 32'(s_st[1]), 0);
    cyc();

    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 399) != 0);
      if (!r0 || mg == 0) begin
        r0 = ($urandom_range(0, 3) != 0);
        w0 = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
        a0 = $urandom & 32'hFFFF_FFFC;
        d0 = $urandom;
      end
      if (!r1 || mg == 1) begin
        r1 = ($urandom_range(0, 2) != 0);
        lk = ($urandom_range(0, 2) == 0);
        w1 = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
        a1 = $urandom & 32'hFFFF_FFFC;
        d1 = $urandom;
      end
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
